cpu_core_mc: RTL
================

# cpu_core_mc

Parametrised multi-cycle successor to the 8-bit accumulator CPU: an 8-entry register file, two's-complement ALU, optional barrel shifter, data RAM and a word-addressed program counter, all sequenced by an explicit fetch/execute/memory/writeback state machine. Instructions arrive over a valid/ready handshake from the instruction source. The core produces PC, the last ALU result and status flags to the surrounding design.

## Interface
- DATA_W, 8, datapath, register and DMEM word width (8..32)
- DMEM_DEPTH, 16, data RAM words; power of 2, at most 2^DATA_W
- PC_W, 9, program counter width (6..12)
- CLK  in  1  rising-edge clock, sole clock
- RESET_N  in  1  reset, synchronous, active-low
- INSTR  in  16  instruction word
- INSTR_VALID  in  1  INSTR is valid
- INSTR_READY  out  1  core accepts INSTR this cycle
- PC  out  PC_W  address of the next instruction to fetch
- ALURESULT  out  DATA_W  last value written to a register or DMEM
- ZERO  out  1  last ALU-class result was zero
- BUSY  out  1  core is not in FETCH
- HALTED  out  1  HALT executed

## Operation
- Fields: op=INSTR[15:12], rd=[11:9], rs1=[8:6], rs2=[5:3], imm8=[7:0], off6=[5:0], tgt=[PC_W-1:0].
- Opcodes:
  - 0 LDI: rd=zext(imm8).
  - 1 MOV: rd=rs2.
  - 2 ADD: rd=rs1+rs2.
  - 3 SUB: rd=rs1+(~rs2+1).
  - 4 AND.
  - 5 OR.
  - 6 SRL: rd=rs1>>rs2[clog2(DATA_W)-1:0].
  - 7 SLL: same shift amount, shifting left.
  - 8 LD: rd=DMEM[rs1 mod DMEM_DEPTH].
  - 9 ST: DMEM[rs1 mod DMEM_DEPTH]=rs2.
  - 10 BEQ: if R[rd]==R[rs1], PC+=sext(off6), else PC+=1.
  - 11 JMP: PC=tgt.
  - 12-14 NOP.
  - 15 HALT.
- Arithmetic wraps modulo 2^DATA_W; carry out is discarded. PC wraps modulo 2^PC_W. Every non-branch/jump instruction advances PC by exactly 1.
- ZERO updates only on opcodes 1-7, and equals (result==0). LD, ST, LDI, branches and NOPs leave it unchanged.
- ALURESULT updates on every register or DMEM write. ST writes rs2's value to ALURESULT.
- States and transitions:
  - FETCH→EXEC on handshake.
  - EXEC→MEM if LD.
  - EXEC→HALT if HALT.
  - Otherwise EXEC→WB.
  - MEM→WB.
  - WB→FETCH.
  - HALT→HALT until reset.
- INSTR is captured into an internal instruction register at the handshake edge. INSTR is don't-care at all other times.
- All eight registers are writable; there is no hardwired zero register.

## Timing
- The handshake completes at the edge where INSTR_VALID=1 and INSTR_READY=1.
- INSTR_READY=1 only in FETCH. It is a function of state only and does not depend on INSTR_VALID.
- For a handshake at edge N:
  - Non-LD instructions: register or DMEM write, PC, ALURESULT and ZERO all update at edge N+2. INSTR_READY is high again in cycle N+2.
  - LD: the DMEM synchronous read happens at N+2. The register write, PC and ALURESULT update at N+3.
- Operands are read in EXEC from the register file. There is no forwarding hazard, because only one instruction is in flight.
- HALT: at edge N+1, HALTED=1 and INSTR_READY=0. PC is not advanced.
- Reset: with RESET_N low at an edge, all registers are cleared regardless of state, and any in-flight instruction is aborted; a store at that same edge is dropped.
  - Cleared to 0: state (FETCH), PC, register file, ALURESULT, ZERO, HALTED.
  - BUSY=0 and INSTR_READY=1 in the cycle after reset.
  - DMEM is not reset; its contents are undefined after power-up.
- The BEQ offset is relative to the BEQ's own PC. off6=0 therefore spins on the same instruction.

## Configuration
- CPU_CORE_SHIFT_EN defined: SRL and SLL are executed by the shift sub-module as specified above.
- CPU_CORE_SHIFT_EN undefined: opcodes 6 and 7 execute as NOPs. They take the same cycle count, make no register write, and leave ZERO and ALURESULT unchanged. The shifter is not instantiated.

## Structure
- Package cpu_core_pkg holds:
  - opcode enum (4 bits)
  - state enum (FETCH, EXEC, MEM, WB, HALT)
  - instruction field bit positions
  - NUM_REGS=8
- Sub-module barrel_shift #(DATA_W): purely combinational, with a direction input and a log2(DATA_W)-bit shift amount, built from log2 stages of 2:1 selection. It is compiled only under CPU_CORE_SHIFT_EN.
- Register file, DMEM and the FSM live in cpu_core_mc.

## Test plan
- Reset: hold RESET_N low for 2 cycles, then release. Expect PC=0, ALURESULT=0, ZERO=0, HALTED=0, INSTR_READY=1.
- ALU, DATA_W=8: LDI r1,0xF0; LDI r2,0x10; ADD r3,r1,r2 → ALURESULT=0x00, ZERO=1, PC=3. Then SUB r4,r2,r1 → 0x20, ZERO=0.
- Memory: ST [r2]=r1 with r2=0x10 and DMEM_DEPTH=16, so address 0. Then LD r5,[r2] → r5=0xF0 written 3 cycles after the LD handshake. ZERO is unchanged.
- Branch and jump: PC=5, BEQ with equal registers and off6=0x3E (−2) → PC=3. With unequal registers → PC=6. JMP tgt=0x1FF → PC=0x1FF, then the next sequential instruction → PC=0.
- Handshake and HALT: hold INSTR_VALID low for 5 cycles in FETCH → no state change. Then issue HALT → HALTED=1, INSTR_READY stays 0 for 10 cycles. Assert RESET_N low mid-HALT → recovers to FETCH.
- Shift option: with the macro, r1=0x81 and r2 holding shift amount 1, SRL → 0x40 and SLL → 0x02. Without the macro, the destination register is unchanged and PC advances by 1.

Source files
------------

// File: rtl/cpu_core_pkg.sv
// cpu_core_pkg: shared types and constants for the multi-cycle core.
//   - opcode_e : 4-bit instruction opcodes
//   - state_e  : sequencer states FETCH/EXEC/MEM/WB/HALT
//   - instruction field bit positions and register-file size
package cpu_core_pkg;

  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;

  // Instruction field positions
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;
  localparam int IMM_W   = 8;
  localparam int OFF_W   = 6;

  typedef enum logic [3:0] {
    OP_LDI  = 4'd0,
    OP_MOV  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_SRL  = 4'd6,
    OP_SLL  = 4'd7,
    OP_LD   = 4'd8,
    OP_ST   = 4'd9,
    OP_BEQ  = 4'd10,
    OP_JMP  = 4'd11,
    OP_NOP0 = 4'd12,
    OP_NOP1 = 4'd13,
    OP_NOP2 = 4'd14,
    OP_HALT = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MEM   = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

endpackage

// File: rtl/cpu_core_if.sv
// cpu_core_if: instruction-source handshake.
//   instr       : 16-bit instruction word
//   instr_valid : source has an instruction on instr
//   instr_ready : core accepts an instruction this cycle
// master = instruction source, slave = core.
interface cpu_core_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;

  modport master (output instr, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/barrel_shift.sv
// barrel_shift: combinational logical shifter, log2(DATA_W) stages of 2:1
// selection. Only compiled when CPU_CORE_SHIFT_EN is defined.
//   data   : value to shift
//   amount : shift distance, SH_W bits
//   left   : 1 = shift left, 0 = shift right (zero fill both ways)
//   result : shifted value
`ifdef CPU_CORE_SHIFT_EN
module barrel_shift #(
  parameter int DATA_W = 8,
  parameter int SH_W   = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [SH_W-1:0]   amount,
  input  logic              left,
  output logic [DATA_W-1:0] result
);
  logic [SH_W:0][DATA_W-1:0] stage;

  assign stage[0] = data;

  // Stage gi moves the value by 2**gi when amount[gi] is set
  for (genvar gi = 0; gi < SH_W; gi++) begin : g_stage
    assign stage[gi+1] = amount[gi]
                         ? (left ? (stage[gi] << (2**gi)) : (stage[gi] >> (2**gi)))
                         : stage[gi];
  end

  assign result = stage[SH_W];
endmodule
`endif

// File: rtl/cpu_core_mc.sv
// cpu_core_mc: multi-cycle register CPU sequenced FETCH->EXEC->(MEM)->WB.
//   clk, reset_n : clock and synchronous active-low reset
//   bus          : instruction handshake (slave side)
//   pc           : address of next instruction to fetch
//   aluresult    : last value written to a register or DMEM
//   zero         : last ALU-class result was zero
//   busy         : core is not in FETCH
//   halted       : HALT executed
// Optional feature macro: CPU_CORE_SHIFT_EN (SRL/SLL via barrel_shift;
// otherwise those opcodes behave as NOPs).
module cpu_core_mc
  import cpu_core_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DMEM_DEPTH = 16,
  parameter int PC_W       = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  cpu_core_if.slave         bus,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] aluresult,
  output logic              zero,
  output logic              busy,
  output logic              halted
);
  localparam int AW   = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
  localparam int SH_W = $clog2(DATA_W);

  state_e            state_reg, state_next;
  logic [15:0]       ir_reg;
  logic [PC_W-1:0]   pc_reg;
  logic [DATA_W-1:0] res_reg;
  logic              zero_reg;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];
  logic [DATA_W-1:0] mem_rdata_reg;

  // Results computed in EXEC, held until the WB commit
  logic [DATA_W-1:0] ex_res_reg;
  logic [PC_W-1:0]   ex_pc_reg;
  logic [AW-1:0]     ex_addr_reg;
  logic              ex_wreg_reg, ex_wmem_reg, ex_zupd_reg, ex_ld_reg;

  opcode_e               op;
  logic [REG_AW-1:0]     rd_idx, rs1_idx, rs2_idx;
  logic [DATA_W-1:0]     a, b, d;
  logic [PC_W-1:0]       off_ext;

  assign op      = opcode_e'(ir_reg[OP_LSB +: 4]);
  assign rd_idx  = ir_reg[RD_LSB +: REG_AW];
  assign rs1_idx = ir_reg[RS1_LSB +: REG_AW];
  assign rs2_idx = ir_reg[RS2_LSB +: REG_AW];
  assign a       = regs[rs1_idx];
  assign b       = regs[rs2_idx];
  assign d       = regs[rd_idx];
  assign off_ext = PC_W'($signed(ir_reg[OFF_W-1:0]));

`ifdef CPU_CORE_SHIFT_EN
  logic [DATA_W-1:0] shift_out;
  barrel_shift #(.DATA_W(DATA_W)) u_shift (
    .data   (a),
    .amount (b[SH_W-1:0]),
    .left   (op == OP_SLL),
    .result (shift_out)
  );
`endif

  // Execute: decode and compute everything the commit needs
  logic [DATA_W-1:0] exe_res;
  logic [PC_W-1:0]   exe_pc;
  logic              exe_wreg, exe_wmem, exe_zupd;

  always_comb begin
    exe_res  = '0;
    exe_pc   = pc_reg + PC_W'(1);
    exe_wreg = 1'b0;
    exe_wmem = 1'b0;
    exe_zupd = 1'b0;
    case (op)
      OP_LDI: begin exe_res = DATA_W'(ir_reg[IMM_W-1:0]); exe_wreg = 1'b1; end
      OP_MOV: begin exe_res = b;                   exe_wreg = 1'b1; exe_zupd = 1'b1; end
      OP_ADD: begin exe_res = a + b;               exe_wreg = 1'b1; exe_zupd = 1'b1; end
      OP_SUB: begin exe_res = a + (~b) + DATA_W'(1); exe_wreg = 1'b1; exe_zupd = 1'b1; end
      OP_AND: begin exe_res = a & b;               exe_wreg = 1'b1; exe_zupd = 1'b1; end
      OP_OR:  begin exe_res = a | b;               exe_wreg = 1'b1; exe_zupd = 1'b1; end
`ifdef CPU_CORE_SHIFT_EN
      OP_SRL, OP_SLL: begin exe_res = shift_out; exe_wreg = 1'b1; exe_zupd = 1'b1; end
`endif
      OP_LD:  exe_wreg = 1'b1;
      OP_ST:  begin exe_res = b; exe_wmem = 1'b1; end
      // Offset is relative to the BEQ's own address
      OP_BEQ: if (d == a) exe_pc = pc_reg + off_ext;
      OP_JMP: exe_pc = ir_reg[PC_W-1:0];
      OP_HALT: exe_pc = pc_reg;
      default: ;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= ST_FETCH;
    else          state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FETCH: if (bus.instr_valid) state_next = ST_EXEC;
      ST_EXEC: begin
        if (op == OP_LD)        state_next = ST_MEM;
        else if (op == OP_HALT) state_next = ST_HALT;
        else                    state_next = ST_WB;
      end
      ST_MEM:  state_next = ST_WB;
      ST_WB:   state_next = ST_FETCH;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_FETCH;
    endcase
  end

  // FSM: outputs (state-only, ready never looks at valid)
  always_comb begin
    bus.instr_ready = (state_reg == ST_FETCH);
    busy            = (state_reg != ST_FETCH);
    halted          = (state_reg == ST_HALT);
  end

  logic [DATA_W-1:0] wb_data;
  assign wb_data = ex_ld_reg ? mem_rdata_reg : ex_res_reg;

  // Architectural state and EXEC/WB hand-off
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_reg      <= '0;
      res_reg     <= '0;
      zero_reg    <= 1'b0;
      ir_reg      <= '0;
      ex_res_reg  <= '0;
      ex_pc_reg   <= '0;
      ex_addr_reg <= '0;
      ex_wreg_reg <= 1'b0;
      ex_wmem_reg <= 1'b0;
      ex_zupd_reg <= 1'b0;
      ex_ld_reg   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (state_reg == ST_FETCH && bus.instr_valid) ir_reg <= bus.instr;
      if (state_reg == ST_EXEC) begin
        ex_res_reg  <= exe_res;
        ex_pc_reg   <= exe_pc;
        ex_addr_reg <= a[AW-1:0];
        ex_wreg_reg <= exe_wreg;
        ex_wmem_reg <= exe_wmem;
        ex_zupd_reg <= exe_zupd;
        ex_ld_reg   <= (op == OP_LD);
      end
      if (state_reg == ST_WB) begin
        pc_reg <= ex_pc_reg;
        if (ex_wreg_reg) begin
          regs[rd_idx] <= wb_data;
          res_reg      <= wb_data;
        end
        if (ex_wmem_reg) res_reg  <= ex_res_reg;
        if (ex_zupd_reg) zero_reg <= (ex_res_reg == '0);
      end
    end
  end

  // Data RAM: no reset on contents; a store coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (reset_n && state_reg == ST_WB && ex_wmem_reg) dmem[ex_addr_reg] <= ex_res_reg;
    if (state_reg == ST_MEM) mem_rdata_reg <= dmem[ex_addr_reg];
  end

  assign pc        = pc_reg;
  assign aluresult = res_reg;
  assign zero      = zero_reg;
endmodule
